sos_cascade_ctrl: RTL and testbench

SOS_CASCADE_CTRL -- requirements
Module: sos_cascade_ctrl

---
 rtl/sos_cascade_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sos_cascade_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sos_cascade_ctrl.sv
// Sequencer for a cascade of biquad sections: a sample enters, is handed to each
// non-bypassed section in order, and the final result is presented on sample_out.
module sos_cascade_ctrl #(
    parameter int NUM_SECTIONS = 4,
    parameter int DATA_SIZE    = 24,
    parameter int TIMEOUT      = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_SIZE-1:0]              sample_in,
    input  logic                              sample_valid,
    input  logic [NUM_SECTIONS-1:0]           bypass,
    input  logic                              clear_err,
    output logic [NUM_SECTIONS-1:0]           sec_trig,
    input  logic [NUM_SECTIONS-1:0]           sec_done,
    output logic [NUM_SECTIONS*DATA_SIZE-1:0] sec_data_in,
    input  logic [NUM_SECTIONS*DATA_SIZE-1:0] sec_data_out,
    output logic [DATA_SIZE-1:0]              sample_out,
    output logic                              sample_out_valid,
    output logic                              busy,
    output logic                              overrun,
    output logic                              timeout_err
);

    // state | meaning
    // IDLE  | waiting for a sample
    // SEL   | pick next section, skip bypassed ones, or finish
    // TRIG  | start pulse to section idx, load its input register
    // WAIT  | wait for done of section idx, bounded by TIMEOUT
    // CAP   | take section idx result into acc
    // OUT   | present the cascade result for one cycle
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_TRIG = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam int IDX_W = $clog2(NUM_SECTIONS + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        wait_cnt;
    logic [DATA_SIZE-1:0]    acc;
    logic [NUM_SECTIONS-1:0] bypass_q;
    logic [DATA_SIZE-1:0]    sec_data_q [NUM_SECTIONS];

    logic                    cur_bypass;
    logic                    cur_done;
    logic [DATA_SIZE-1:0]    cur_result;
    logic                    idx_end;
    logic                    timeout_hit;

    // Pick out the bypass, done and result belonging to section idx; drive its trigger
    always_comb begin
        cur_bypass = 1'b0;
        cur_done   = 1'b0;
        cur_result = '0;
        sec_trig   = '0;
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_bypass  = bypass_q[i];
                cur_done    = sec_done[i];
                cur_result  = sec_data_out[i*DATA_SIZE +: DATA_SIZE];
                sec_trig[i] = (state == S_TRIG);
            end
        end
    end

    assign idx_end     = (idx == IDX_W'(NUM_SECTIONS));
    // The last counted wait cycle: the counter would reach TIMEOUT on this edge
    assign timeout_hit = (state == S_WAIT) && !cur_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign busy        = (state != S_IDLE);

    // Sequencer state, section index, wait counter, accumulator and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            idx              <= '0;
            wait_cnt         <= '0;
            acc              <= '0;
            bypass_q         <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        acc      <= sample_in;
                        bypass_q <= bypass;
                        idx      <= '0;
                        state    <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (idx_end) begin
                        sample_out       <= acc;
                        sample_out_valid <= 1'b1;
                        state            <= S_OUT;
                    end else if (cur_bypass) begin
                        idx <= idx + IDX_W'(1);
                    end else begin
                        state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (cur_done) begin
                        state <= S_CAP;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_CAP: begin
                    acc   <= cur_result;
                    idx   <= idx + IDX_W'(1);
                    state <= S_SEL;
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Section input registers: each one loads only when its own section is triggered
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                sec_data_q[i] <= '0;
            end
        end else if (state == S_TRIG) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                if (idx == IDX_W'(i)) begin
                    sec_data_q[i] <= acc;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SECTIONS; g++) begin : g_slice
        assign sec_data_in[g*DATA_SIZE +: DATA_SIZE] = sec_data_q[g];
    end

    // Sticky error flags; a new error event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (sample_valid && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Scoreboard bench for sos_cascade_ctrl with behavioural section models.
module tb_sos_cascade_ctrl;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int TO = 15;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   sample_in;
    logic            sample_valid;
    logic [N-1:0]    bypass;
    logic            clear_err;
    logic [N-1:0]    sec_trig;
    logic [N-1:0]    sec_done;
    logic [N*DW-1:0] sec_data_in;
    logic [N*DW-1:0] sec_data_out;
    logic [DW-1:0]   sample_out;
    logic            sample_out_valid;
    logic            busy;
    logic            overrun;
    logic            timeout_err;

    sos_cascade_ctrl #(
        .NUM_SECTIONS(N),
        .DATA_SIZE   (DW),
        .TIMEOUT     (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .bypass          (bypass),
        .clear_err       (clear_err),
        .sec_trig        (sec_trig),
        .sec_done        (sec_done),
        .sec_data_in     (sec_data_in),
        .sec_data_out    (sec_data_out),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .busy            (busy),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_out_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] mask;
    } exp_trig_t;

    exp_out_t  oq[$];
    exp_trig_t tq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pend [N];
    logic stall [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number of the current clock period, stable between rising edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Section models: done two cycles after trigger, result = input + 1
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            sec_done[i] = 1'b0;
            if (pend[i] > 0) begin
                pend[i] = pend[i] - 1;
                if (pend[i] == 0 && !stall[i]) begin
                    sec_done[i] = 1'b1;
                    sec_data_out[i*DW +: DW] = sec_data_in[i*DW +: DW] + 24'd1;
                end
            end
            if (sec_trig[i] === 1'b1) pend[i] = 2;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (sample_out_valid === 1'b1) begin
            if (oq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data %0h at cycle %0d, expected no output", sample_out, cyc);
            end else begin
                exp_out_t e;
                e = oq.pop_front();
                check("out_data", sample_out, e.data);
                check("out_cycle", cyc, e.cyc);
            end
        end
    end

    // Trigger monitor
    always @(negedge clk) begin
        if (sec_trig !== '0) begin
            if (tq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trig: got %0h at cycle %0d, expected none", sec_trig, cyc);
            end else begin
                exp_trig_t e;
                e = tq.pop_front();
                check("trig_mask", sec_trig, e.mask);
                check("trig_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic goto_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_sample(input logic [DW-1:0] d, input logic [N-1:0] byp, output int t0);
        @(negedge clk);
        sample_in    = d;
        bypass       = byp;
        sample_valid = 1'b1;
        t0           = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic push_out(input int c, input logic [DW-1:0] d);
        exp_out_t e;
        e.cyc  = c;
        e.data = d;
        oq.push_back(e);
    endtask

    task automatic push_trig(input int c, input logic [N-1:0] m);
        exp_trig_t e;
        e.cyc  = c;
        e.mask = m;
        tq.push_back(e);
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_outq_empty"}, oq.size(), 0);
        check({tag, "_trigq_empty"}, tq.size(), 0);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic full_run(input logic [DW-1:0] d, input string tag);
        int t0;
        start_sample(d, 4'b0000, t0);
        for (int s = 0; s < N; s++) push_trig(t0 + 2 + 5*s, 4'(1 << s));
        push_out(t0 + 22, d + 24'd4);
        goto_cycle(t0 + 23);
        drain(tag);
    endtask

    initial begin
        int t0;
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        bypass       = '0;
        clear_err    = 1'b0;
        sec_done     = '0;
        sec_data_out = '0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            stall[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_trig", sec_trig, 4'h0);
        check("rst_out", sample_out, 24'h0);
        check("rst_out_valid", sample_out_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_sec_data_in", sec_data_in, 96'h0);
        reset = 1'b0;

        // All sections active
        start_sample(24'h000010, 4'b0000, t0);
        for (int s = 0; s < N; s++) push_trig(t0 + 2 + 5*s, 4'(1 << s));
        push_out(t0 + 22, 24'h000014);
        goto_cycle(t0 + 3);
        check("t1_slice0_load", sec_data_in[0 +: DW], 24'h000010);
        check("t1_busy", busy, 1'b1);
        goto_cycle(t0 + 8);
        check("t1_slice0_hold", sec_data_in[0 +: DW], 24'h000010);
        check("t1_slice1_load", sec_data_in[DW +: DW], 24'h000011);
        goto_cycle(t0 + 24);
        check("t1_out_hold", sample_out, 24'h000014);
        check("t1_slices", sec_data_in, 96'h000013_000012_000011_000010);
        drain("t1");

        // Sections 0 and 2 bypassed; bypass changes mid-sample are ignored
        start_sample(24'h000010, 4'b0101, t0);
        bypass = 4'b1111;
        push_trig(t0 + 3, 4'b0010);
        push_trig(t0 + 9, 4'b1000);
        push_out(t0 + 14, 24'h000012);
        goto_cycle(t0 + 15);
        drain("t2");

        // Everything bypassed
        start_sample(24'hABCDEF, 4'b1111, t0);
        push_out(t0 + 6, 24'hABCDEF);
        goto_cycle(t0 + 7);
        drain("t3");

        // Overrun: samples mid-sequence and in OUT are dropped
        start_sample(24'h000010, 4'b0000, t0);
        for (int s = 0; s < N; s++) push_trig(t0 + 2 + 5*s, 4'(1 << s));
        push_out(t0 + 22, 24'h000014);
        goto_cycle(t0 + 5);
        check("t4_overrun_pre", overrun, 1'b0);
        sample_in    = 24'hDEAD00;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("t4_overrun_set", overrun, 1'b1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t4_overrun_clr", overrun, 1'b0);
        goto_cycle(t0 + 22);
        sample_in    = 24'hBEEF00;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("t4_overrun_out", overrun, 1'b1);
        check("t4_not_accepted", busy, 1'b0);
        drain("t4");
        pulse_clear();
        check("t4_overrun_clr2", overrun, 1'b0);

        // Section 2 never finishes; clear_err coincides with the timeout event
        stall[2] = 1'b1;
        start_sample(24'h000010, 4'b0000, t0);
        push_trig(t0 + 2, 4'b0001);
        push_trig(t0 + 7, 4'b0010);
        push_trig(t0 + 12, 4'b0100);
        goto_cycle(t0 + 12 + TO);
        check("t5_timeout_early", timeout_err, 1'b0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t5_timeout_set", timeout_err, 1'b1);
        @(negedge clk);
        check("t5_busy_after", busy, 1'b0);
        drain("t5");
        stall[2] = 1'b0;
        pulse_clear();
        check("t5_timeout_clr", timeout_err, 1'b0);
        full_run(24'h000100, "t5b");

        // Reset during WAIT of section 1
        start_sample(24'h000010, 4'b0000, t0);
        push_trig(t0 + 2, 4'b0001);
        push_trig(t0 + 7, 4'b0010);
        goto_cycle(t0 + 8);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 1'b0);
        check("t6_trig", sec_trig, 4'h0);
        check("t6_out", sample_out, 24'h0);
        check("t6_out_valid", sample_out_valid, 1'b0);
        check("t6_sec_data_in", sec_data_in, 96'h0);
        check("t6_flags", {overrun, timeout_err}, 2'b00);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        drain("t6");
        full_run(24'h000010, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
